// File: rtl/ad5722_spi_responder_pkg.sv
// Shared definitions for the 24-bit DAC command protocol, used by both the
// DAC controller (command builder) and the SPI responder (decoder).
package ad5722_spi_responder_pkg;

  localparam int FRAME_W = 24;
  localparam int DATA_W  = 20;
  localparam int ADDR_W  = 3;
  localparam int RW_BIT  = 23;
  localparam int CNT_W   = 5;

  localparam logic [CNT_W-1:0]  FRAME_CNT = 5'd24;
  localparam logic [ADDR_W-1:0] ADDR_DAC  = 3'b001;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_END   = 2'd2
  } state_t;

  function automatic logic [FRAME_W-1:0] make_cmd(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/ad5722_spi_responder_if.sv
// SPI bus between the DAC controller (master) and the responder (slave).
interface ad5722_spi_responder_if;
  // Frame protocol: scs low brackets a frame; sck idles low; the master changes
  // sdi on sck rising edges and the responder samples it on sck falling edges,
  // MSB first. The responder presents sdo on scs fall and advances it on each
  // sck rising edge; the master samples sdo just before raising sck.
  logic spi_scs_in;
  logic spi_sck_in;
  logic spi_sdi_in;
  logic spi_sdo_out;

  modport master (
    output spi_scs_in,
    output spi_sck_in,
    output spi_sdi_in,
    input  spi_sdo_out
  );

  modport slave (
    input  spi_scs_in,
    input  spi_sck_in,
    input  spi_sdi_in,
    output spi_sdo_out
  );
endinterface

// File: rtl/ad5722_spi_responder_sync_edge.sv
// Two-flop synchronizer with a history flop for rise/fall pulse detection.
module sync_edge (
  input  logic clk,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  // Left unreset so a reset taken mid-frame does not fabricate a fresh
  // chip-select edge from the still-low pin.
  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge clk) begin
    meta <= d;
    sync <= meta;
    hist <= sync;
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/ad5722_spi_responder.sv
// SPI responder emulating the DAC: decodes 24-bit command frames into register
// writes, supports readback on SDO, and models the LDAC/CLR output register.
module ad5722_spi_responder
  import ad5722_spi_responder_pkg::*;
#(
  parameter logic [DATA_W-1:0] CTRL_RESET      = 20'h00000,
  parameter int                MIN_HALF_PERIOD = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  ad5722_spi_responder_if.slave spi,
  input  logic                 ldac_in,
  input  logic                 clr_in,
  output logic [DATA_W-1:0]    dac_in_reg_out,
  output logic [DATA_W-1:0]    dac_out,
  output logic [DATA_W-1:0]    ctrl_out,
  output logic                 frame_valid_out,
  output logic [ADDR_W-1:0]    frame_addr_out,
  output logic                 frame_err_out,
  output state_t               state_dbg
);

  logic scs_level, scs_rise, scs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic sdi_level, sdi_rise, sdi_fall;
  logic ldac_level, ldac_rise, ldac_fall;
  logic clr_level, clr_rise, clr_fall;

  sync_edge u_sync_scs (
    .clk(clk_in), .d(spi.spi_scs_in),
    .level(scs_level), .rise(scs_rise), .fall(scs_fall)
  );
  sync_edge u_sync_sck (
    .clk(clk_in), .d(spi.spi_sck_in),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge u_sync_sdi (
    .clk(clk_in), .d(spi.spi_sdi_in),
    .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall)
  );
  sync_edge u_sync_ldac (
    .clk(clk_in), .d(ldac_in),
    .level(ldac_level), .rise(ldac_rise), .fall(ldac_fall)
  );
  sync_edge u_sync_clr (
    .clk(clk_in), .d(clr_in),
    .level(clr_level), .rise(clr_rise), .fall(clr_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{scs_level, sck_level, sdi_rise, sdi_fall,
                         ldac_rise, ldac_fall, clr_rise, clr_fall};

  state_t             state;
  state_t             state_next;
  logic               start;
  logic               shift_en;
  logic               sdo_adv;
  logic               frame_end;
  logic               commit;

  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] rb_word;
  logic               rb_valid;
  logic [FRAME_W-1:0] sdo_sh;
  logic [CNT_W-1:0]   sdo_left;
  logic [ADDR_W-1:0]  frame_addr;
  logic [DATA_W-1:0]  frame_data;
  logic [DATA_W-1:0]  rb_data;
  logic [7:0]         sck_gap;

  assign frame_addr = shreg[RW_BIT-1 -: ADDR_W];
  assign frame_data = shreg[DATA_W-1:0];
  assign state_dbg  = state;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A shift and a frame end seen in the same sample both happen: the shift
  // lands in shreg on this edge and the commit reads it one cycle later.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    sdo_adv    = 1'b0;
    frame_end  = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (scs_fall) begin
          start      = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = sck_fall;
        sdo_adv  = sck_rise && (sdo_left != '0);
        if (scs_rise) begin
          frame_end  = 1'b1;
          state_next = ST_END;
        end
      end
      ST_END: begin
        commit     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rb_data = '0;
    case (frame_addr)
      ADDR_DAC:  rb_data = dac_in_reg_out;
      ADDR_CTRL: rb_data = ctrl_out;
      default:   rb_data = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shreg           <= '0;
      bit_cnt         <= '0;
      rb_word         <= '0;
      rb_valid        <= 1'b0;
      sdo_sh          <= '0;
      sdo_left        <= '0;
      dac_in_reg_out  <= '0;
      ctrl_out        <= CTRL_RESET;
      frame_valid_out <= 1'b0;
      frame_err_out   <= 1'b0;
      frame_addr_out  <= '0;
    end else begin
      frame_valid_out <= 1'b0;
      frame_err_out   <= 1'b0;

      // A pending readback word is handed to the SDO shifter at the start of
      // the next frame; the MSB is visible before the first sck rise.
      if (start) begin
        bit_cnt <= '0;
        shreg   <= '0;
        if (rb_valid) begin
          sdo_sh   <= rb_word;
          sdo_left <= FRAME_CNT;
          rb_valid <= 1'b0;
          rb_word  <= '0;
        end
      end

      if (shift_en) begin
        shreg <= {shreg[FRAME_W-2:0], sdi_level};
        if (bit_cnt != '1) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (sdo_adv) begin
        sdo_sh   <= {sdo_sh[FRAME_W-2:0], 1'b0};
        sdo_left <= sdo_left - 1'b1;
      end

      if (frame_end) begin
        sdo_left <= '0;
      end

      if (commit) begin
        if (bit_cnt == FRAME_CNT) begin
          frame_valid_out <= 1'b1;
          frame_addr_out  <= frame_addr;
          if (shreg[RW_BIT]) begin
            rb_word  <= {1'b1, frame_addr, rb_data};
            rb_valid <= 1'b1;
          end else begin
            case (frame_addr)
              ADDR_DAC:  dac_in_reg_out <= frame_data;
              ADDR_CTRL: ctrl_out       <= frame_data;
              default: ;
            endcase
          end
        end else begin
          frame_err_out <= 1'b1;
          rb_valid      <= 1'b0;
          rb_word       <= '0;
        end
      end
    end
  end

  assign spi.spi_sdo_out = (sdo_left != '0) & sdo_sh[FRAME_W-1];

  // Clear dominates; a low LDAC (including its falling edge) copies the
  // input register through with one cycle of delay; otherwise hold.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dac_out <= '0;
    end else if (!clr_level) begin
      dac_out <= '0;
    end else if (!ldac_level) begin
      dac_out <= dac_in_reg_out;
    end
  end

  // Cycles since the last synchronized sck edge, to catch a master that
  // clocks faster than the synchronizers can follow.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sck_gap <= '1;
    end else if (sck_rise || sck_fall) begin
      assert ((state != ST_SHIFT) || (int'(sck_gap) >= MIN_HALF_PERIOD));
      sck_gap <= 8'd1;
    end else if (sck_gap != '1) begin
      sck_gap <= sck_gap + 1'b1;
    end
  end

endmodule

// File: tb/tb_ad5722_spi_responder.sv
// Directed and randomized frames against a command-level model of the DAC
// register map, readback queue and LDAC/CLR behaviour.
module tb_ad5722_spi_responder;
  import ad5722_spi_responder_pkg::*;

  localparam logic [19:0] CTRL_INIT = 20'h0A5A5;
  localparam int          W         = 45;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        ldac = 1'b0;
  logic        clr  = 1'b1;
  logic [19:0] dac_in_reg;
  logic [19:0] dac_out;
  logic [19:0] ctrl;
  logic        frame_valid;
  logic        frame_err;
  logic [2:0]  frame_addr;
  state_t      state_dbg;

  ad5722_spi_responder_if spi ();

  ad5722_spi_responder #(
    .CTRL_RESET(CTRL_INIT),
    .MIN_HALF_PERIOD(2)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .spi(spi),
    .ldac_in(ldac),
    .clr_in(clr),
    .dac_in_reg_out(dac_in_reg),
    .dac_out(dac_out),
    .ctrl_out(ctrl),
    .frame_valid_out(frame_valid),
    .frame_addr_out(frame_addr),
    .frame_err_out(frame_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  // entry = {valid, err, addr, dac_in_reg, ctrl} captured on each pulse
  always @(negedge clk) begin
    if (frame_valid || frame_err) begin
      obs_q.push_back({frame_valid, frame_err, frame_addr, dac_in_reg, ctrl});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    logic [W-1:0] e;
    logic [W-1:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      check(tag, 64'(o), 64'(e));
    end
    check({tag, "_extra_pulses"}, 64'(obs_q.size()), 64'd0);
    obs_q.delete();
  endtask

  // ---------------- reference model ----------------
  logic [19:0] m_dac;
  logic [19:0] m_ctrl;
  logic [2:0]  m_addr;
  logic [23:0] m_rb;
  logic        m_rb_valid;

  task automatic model_reset();
    m_dac      = '0;
    m_ctrl     = CTRL_INIT;
    m_addr     = '0;
    m_rb       = '0;
    m_rb_valid = 1'b0;
  endtask

  function automatic logic [19:0] reg_of(input logic [2:0] a);
    if (a == ADDR_DAC)  return m_dac;
    if (a == ADDR_CTRL) return m_ctrl;
    return 20'h0;
  endfunction

  task automatic model_start(output logic [23:0] sdo_exp);
    sdo_exp    = m_rb_valid ? m_rb : 24'h0;
    m_rb_valid = 1'b0;
  endtask

  task automatic model_end(input logic [31:0] word, input int nbits);
    logic [23:0] f;
    f = word[23:0];
    if (nbits != 24) begin
      m_rb_valid = 1'b0;
      exp_q.push_back({1'b0, 1'b1, m_addr, m_dac, m_ctrl});
    end else begin
      m_addr = f[22:20];
      if (f[23]) begin
        m_rb       = {1'b1, f[22:20], reg_of(f[22:20])};
        m_rb_valid = 1'b1;
      end else if (f[22:20] == ADDR_DAC) begin
        m_dac = f[19:0];
      end else if (f[22:20] == ADDR_CTRL) begin
        m_ctrl = f[19:0];
      end
      exp_q.push_back({1'b1, 1'b0, m_addr, m_dac, m_ctrl});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, input int half, output logic s);
    s = spi.spi_sdo_out;
    spi.spi_sdi_in = b;
    spi.spi_sck_in = 1'b1;
    repeat (half) @(negedge clk);
    spi.spi_sck_in = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] word, input int nbits, input int half,
                       output logic [23:0] got, output logic [23:0] want);
    logic s;
    model_start(want);
    got = '0;
    spi.spi_scs_in = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      clock_bit(word[i], half, s);
      got = {got[22:0], s};
    end
    spi.spi_scs_in = 1'b1;
    model_end(word, nbits);
  endtask

  task automatic wait_pulse(output int lat);
    lat = 0;
    while (!(frame_valid || frame_err) && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [23:0] got;
    logic [23:0] want;
    logic [19:0] prev_dac;
    logic [31:0] word;
    logic        s;
    int          lat;

    spi.spi_scs_in = 1'b1;
    spi.spi_sck_in = 1'b0;
    spi.spi_sdi_in = 1'b0;
    model_reset();
    idle(6);
    rst = 1'b0;
    @(negedge clk);

    check("rst_dac_in", 64'(dac_in_reg), 64'h0);
    check("rst_dac_out", 64'(dac_out), 64'h0);
    check("rst_ctrl", 64'(ctrl), 64'(CTRL_INIT));
    check("rst_sdo", 64'(spi.spi_sdo_out), 64'h0);
    check("rst_valid", 64'(frame_valid), 64'h0);
    check("rst_err", 64'(frame_err), 64'h0);
    check("rst_addr", 64'(frame_addr), 64'h0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));

    // DAC write with LDAC held low
    frame(32'h1ABCDE, 24, 2, got, want);
    wait_pulse(lat);
    check("wr_latency", 64'(lat), 64'd4);
    check("wr_dac_in", 64'(dac_in_reg), 64'h0ABCDE);
    check("wr_addr", 64'(frame_addr), 64'd1);
    check("wr_dac_out_before", 64'(dac_out), 64'h0);
    @(negedge clk);
    check("wr_dac_out_after", 64'(dac_out), 64'h0ABCDE);
    check("wr_pulse_once", 64'(frame_valid), 64'h0);
    idle(6);
    drain("wr");

    // control write, reads, and readback on the following frames
    frame(32'h200002, 24, 2, got, want);
    idle(3);
    frame(32'hA00000, 24, 2, got, want);
    idle(3);
    frame(32'h012345, 24, 4, got, want);
    check("rb_ctrl", 64'(got), 64'hA00002);
    idle(3);
    frame(32'h900000, 24, 2, got, want);
    idle(3);
    frame(32'h300001, 24, 4, got, want);
    check("rb_dac", 64'(got), 64'(want));
    idle(3);
    frame(32'hF00000, 24, 2, got, want);
    idle(3);
    frame(32'h000000, 24, 4, got, want);
    check("rb_unmapped", 64'(got), 64'(want));
    idle(3);
    frame(32'h000000, 24, 4, got, want);
    check("rb_consumed", 64'(got), 64'(want));
    idle(8);
    drain("decode");

    // short and long frames
    frame(32'h155555, 23, 2, got, want);
    idle(3);
    frame(32'h0122222, 25, 2, got, want);
    idle(3);
    frame(32'hA00000, 24, 2, got, want);
    idle(3);
    frame(32'h0, 23, 2, got, want);
    idle(3);
    frame(32'h000000, 24, 4, got, want);
    check("rb_after_err", 64'(got), 64'(want));
    idle(8);
    check("len_dac_in", 64'(dac_in_reg), 64'(m_dac));
    check("len_ctrl", 64'(ctrl), 64'(m_ctrl));
    drain("length");

    // LDAC / CLR
    prev_dac = dac_out;
    ldac = 1'b1;
    idle(5);
    frame(32'h17FFFF, 24, 2, got, want);
    idle(10);
    check("ldac_hi_dac_in", 64'(dac_in_reg), 64'h7FFFF);
    check("ldac_hi_hold", 64'(dac_out), 64'(prev_dac));
    ldac = 1'b0;
    idle(5);
    check("ldac_fall_load", 64'(dac_out), 64'h7FFFF);
    ldac = 1'b1;
    clr = 1'b0;
    idle(5);
    check("clr_dac_out", 64'(dac_out), 64'h0);
    check("clr_dac_in", 64'(dac_in_reg), 64'h7FFFF);
    clr = 1'b1;
    idle(5);
    check("clr_release_hold", 64'(dac_out), 64'h0);
    ldac = 1'b0;
    idle(5);
    check("ldac_low_follow", 64'(dac_out), 64'h7FFFF);

    // zero-length frame
    frame(32'h0, 0, 2, got, want);
    idle(8);
    drain("ldac_zero_len");

    // reset in the middle of a frame
    model_start(want);
    spi.spi_scs_in = 1'b0;
    idle(2);
    word = 32'h155555;
    for (int i = 23; i >= 12; i--) clock_bit(word[i], 2, s);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    model_reset();
    idle(2);
    spi.spi_scs_in = 1'b1;
    idle(10);
    check("mid_rst_no_pulse", 64'(obs_q.size()), 64'd0);
    check("mid_rst_dac_in", 64'(dac_in_reg), 64'h0);
    check("mid_rst_dac_out", 64'(dac_out), 64'h0);
    check("mid_rst_ctrl", 64'(ctrl), 64'(CTRL_INIT));
    check("mid_rst_addr", 64'(frame_addr), 64'h0);
    check("mid_rst_state", 64'(state_dbg), 64'(ST_IDLE));
    frame(32'h20BEEF, 24, 2, got, want);
    idle(8);
    check("post_rst_ctrl", 64'(ctrl), 64'h0BEEF);
    drain("reset");

    // back-to-back random stream with minimum gaps
    for (int n = 0; n < 300; n++) begin
      word = {8'h0, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
              20'($urandom())};
      frame(word, 24, 2, got, want);
      idle(3);
    end
    idle(8);
    drain("stream");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
